// File: rtl/wb_uart_rx.sv
// Wishbone UART receiver; WB_UART_RX_FIFO_EN selects a 4-entry FIFO instead of a single holding register.
// Ack 1 cycle after strobe, byte readable 1 cycle after stop sample; no backpressure: full buffer drops and flags overrun.
module wb_uart_rx #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     uart_rx_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
    input  logic                     wb_we_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    output logic                     wb_ack_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    output logic                     rx_irq_o
);

    localparam logic [31:0] SANITY_VAL = 32'h5EC0B0B0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               sync_q, sync_d;
    logic [1:0]               settle_q, settle_d;
    logic                     rx_prev_q, rx_prev_d;
    logic [16:0]              timer_q, timer_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic [7:0]               shift_q, shift_d;
    logic [15:0]              div_q, div_d;
    logic                     ack_q, ack_d;
    logic [WB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                     overrun_q, overrun_d;
    logic                     frame_err_q, frame_err_d;
    logic [2:0]               count_q, count_d;

    logic        rx_s;
    logic [16:0] period, half;
    logic        req, wr, rd;
    logic [1:0]  reg_sel;
    logic        push_req, push_ok, pop, set_ovr, frame_bad;
    logic        clr_ovr, clr_ferr;
    logic [7:0]  head;
    logic [31:0] status, reg_rd;
    logic        unused_bits;

    assign rx_s   = sync_q[1];
    assign period = {1'b0, div_q} + 17'd2;
    assign half   = {1'b0, period[16:1]};

    assign req     = wb_cyc_i && wb_stb_i && !ack_q;
    assign wr      = req && wb_we_i;
    assign rd      = req && !wb_we_i;
    assign reg_sel = wb_addr_i[3:2];

    assign unused_bits = ^{wb_addr_i, wb_data_i, wb_sel_i};

    // Synchronizer powers up high, so the edge detector is held off until real line samples arrive.
    always_comb begin
        sync_d    = {sync_q[0], uart_rx_i};
        settle_d  = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        rx_prev_d = (settle_q == 2'd2) ? rx_s : 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        frame_bad = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    timer_d   = half - 17'd1;
                    bit_cnt_d = 3'd0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (timer_q == 17'd0) begin
                    if (!rx_s) begin
                        timer_d = period - 17'd1;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q - 17'd1;
                end
            end
            S_DATA: begin
                if (timer_q == 17'd0) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    timer_d   = period - 17'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    timer_d = timer_q - 17'd1;
                end
            end
            S_STOP: begin
                if (timer_q == 17'd0) begin
                    state_d   = S_IDLE;
                    push_req  = rx_s;
                    frame_bad = !rx_s;
                end else begin
                    timer_d = timer_q - 17'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef WB_UART_RX_FIFO_EN
    localparam logic [2:0] DEPTH = 3'd4;

    logic [7:0] mem_q [4];
    logic [7:0] mem_d [4];
    logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q    <= '{default: 8'h00};
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
`else
    localparam logic [2:0] DEPTH = 3'd1;

    logic [7:0] hold_q, hold_d;

    assign head = hold_q;

    always_comb begin
        hold_d = push_ok ? shift_q : hold_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hold_q <= 8'h00;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    // A pop in the same cycle frees the slot, so a push into a full buffer still lands.
    assign pop     = rd && (reg_sel == 2'd1) && (count_q != 3'd0);
    assign push_ok = push_req && ((count_q != DEPTH) || pop);
    assign set_ovr = push_req && !push_ok;

    assign clr_ovr  = wr && (reg_sel == 2'd2) && wb_sel_i[0] && wb_data_i[1];
    assign clr_ferr = wr && (reg_sel == 2'd2) && wb_sel_i[0] && wb_data_i[2];
    assign status   = {25'd0, count_q, 1'b0, frame_err_q, overrun_q, count_q != 3'd0};

    always_comb begin
        count_d     = count_q + {2'b00, push_ok} - {2'b00, pop};
        overrun_d   = set_ovr || (overrun_q && !clr_ovr);
        frame_err_d = frame_bad || (frame_err_q && !clr_ferr);
        div_d       = div_q;
        if (wr && (reg_sel == 2'd0)) begin
            if (wb_sel_i[0]) div_d[7:0]  = wb_data_i[7:0];
            if (wb_sel_i[1]) div_d[15:8] = wb_data_i[15:8];
        end
    end

    always_comb begin
        ack_d  = req;
        reg_rd = 32'd0;
        case (reg_sel)
            2'd0:    reg_rd = {16'd0, div_q};
            2'd1:    reg_rd = (count_q != 3'd0) ? {24'd0, head} : 32'd0;
            2'd2:    reg_rd = status;
            default: reg_rd = SANITY_VAL;
        endcase
        rdata_d = rd ? WB_DATA_WIDTH'(reg_rd) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            sync_q      <= 2'b11;
            settle_q    <= 2'd0;
            rx_prev_q   <= 1'b0;
            timer_q     <= 17'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            div_q       <= 16'd1;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            count_q     <= 3'd0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            settle_q    <= settle_d;
            rx_prev_q   <= rx_prev_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            div_q       <= div_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            count_q     <= count_d;
        end
    end

    assign wb_ack_o  = ack_q && wb_cyc_i;
    assign wb_data_o = rdata_q;
    assign rx_irq_o  = count_q != 3'd0;

endmodule

// File: tb/tb_wb_uart_rx.sv
// Bench for wb_uart_rx: directed UART frames and Wishbone accesses; read data checked by a scoreboard monitor.
module tb_wb_uart_rx;

    localparam logic [3:0] A_DIV = 4'h0, A_RX = 4'h4, A_ST = 4'h8, A_SAN = 4'hC;
`ifdef WB_UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        uart_rx;
    logic [31:0] wb_addr;
    logic [31:0] wb_wdat;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb;
    logic        wb_ack;
    logic [31:0] wb_rdat;
    logic        rx_irq;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        chk;
        logic [31:0] dat;
    } exp_t;

    exp_t  sb_q[$];
    string sb_name[$];
    exp_t  mon_e;
    string mon_n;

    always #5 clk = ~clk;

    wb_uart_rx dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .uart_rx_i (uart_rx),
        .wb_addr_i (wb_addr),
        .wb_data_i (wb_wdat),
        .wb_sel_i  (wb_sel),
        .wb_we_i   (wb_we),
        .wb_cyc_i  (wb_cyc),
        .wb_stb_i  (wb_stb),
        .wb_ack_o  (wb_ack),
        .wb_data_o (wb_rdat),
        .rx_irq_o  (rx_irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wb_ack) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack with no pending access, expected none");
            end else begin
                mon_e = sb_q.pop_front();
                mon_n = sb_name.pop_front();
                if (mon_e.chk) check(mon_n, wb_rdat, mon_e.dat);
            end
        end
    end

    task automatic wb_xfer(input logic we, input logic [3:0] addr, input logic [31:0] wdat,
                           input logic [31:0] exp, input string name);
        exp_t e;
        logic got;
        e.chk = !we;
        e.dat = exp;
        sb_q.push_back(e);
        sb_name.push_back(name);
        @(posedge clk);
        #1;
        wb_addr = {28'h0, addr};
        wb_wdat = wdat;
        wb_we   = we;
        wb_cyc  = 1'b1;
        wb_stb  = 1'b1;
        got     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wb_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no ack in 8 cycles, expected ack", name);
            void'(sb_q.pop_back());
            void'(sb_name.pop_back());
        end else begin
            // Strobe still held: ack must drop after a single cycle anyway.
            @(negedge clk);
            check({name, "_ack_pulse"}, {31'd0, wb_ack}, 32'd0);
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
    endtask

    task automatic rd(input logic [3:0] addr, input logic [31:0] exp, input string name);
        wb_xfer(1'b0, addr, 32'd0, exp, name);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] dat, input string name);
        wb_xfer(1'b1, addr, dat, 32'd0, name);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int p);
        @(posedge clk);
        #1 uart_rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (p) @(posedge clk);
            #1 uart_rx = b[i];
        end
        repeat (p) @(posedge clk);
        #1 uart_rx = stop_bit;
        repeat (p) @(posedge clk);
        #1 uart_rx = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        wb_addr = 32'd0;
        wb_wdat = 32'd0;
        wb_sel  = 4'hF;
        wb_we   = 1'b0;
        wb_cyc  = 1'b0;
        wb_stb  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", {31'd0, wb_ack}, 32'd0);
        check("rst_data", wb_rdat, 32'd0);
        check("rst_irq", {31'd0, rx_irq}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);

        rd(A_SAN, 32'h5EC0B0B0, "sanity");
        rd(A_DIV, 32'd1, "div_reset");
        rd(A_ST, 32'h0, "status_reset");
        wr(A_RX, 32'hAA, "wr_rxdata");
        wr(A_SAN, 32'h0, "wr_sanity");
        rd(A_SAN, 32'h5EC0B0B0, "sanity_after_wr");
        rd(A_ST, 32'h0, "status_after_ro_wr");
        wr(A_DIV, 32'd8, "wr_div");
        rd(A_DIV, 32'd8, "div_8");

        // Stop sample lands 97 clocks after the start edge is driven; irq follows one clock later.
        fork
            send_frame(8'hA5, 1'b1, 10);
            begin
                repeat (98) @(posedge clk);
                @(negedge clk);
                check("irq_before_stop", {31'd0, rx_irq}, 32'd0);
                @(negedge clk);
                check("irq_after_stop", {31'd0, rx_irq}, 32'd1);
            end
        join
        rd(A_ST, 32'h11, "status_a5");
        rd(A_RX, 32'hA5, "rx_a5");
        rd(A_ST, 32'h00, "status_a5_popped");
        rd(A_RX, 32'h00, "rx_empty");

        @(posedge clk);
        #1 uart_rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (30) @(posedge clk);
        rd(A_ST, 32'h00, "status_glitch");
        check("irq_glitch", {31'd0, rx_irq}, 32'd0);
        send_frame(8'h3C, 1'b1, 10);
        rd(A_RX, 32'h3C, "rx_3c");

        send_frame(8'h55, 1'b0, 10);
        rd(A_ST, 32'h04, "status_ferr");
        rd(A_RX, 32'h00, "rx_ferr_empty");
        wr(A_ST, 32'h4, "clr_ferr");
        rd(A_ST, 32'h00, "status_ferr_clr");

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 10);
`ifdef WB_UART_RX_FIFO_EN
        rd(A_ST, 32'h43, "status_ovr");
        rd(A_RX, 32'h01, "rx_ovr_1");
        rd(A_RX, 32'h02, "rx_ovr_2");
        rd(A_RX, 32'h03, "rx_ovr_3");
        rd(A_RX, 32'h04, "rx_ovr_4");
`else
        rd(A_ST, 32'h13, "status_ovr");
        rd(A_RX, 32'h01, "rx_ovr_1");
`endif
        rd(A_RX, 32'h00, "rx_ovr_empty");
        rd(A_ST, 32'h02, "status_ovr_only");
        wr(A_ST, 32'h2, "clr_ovr");
        rd(A_ST, 32'h00, "status_ovr_clr");

        // Fill the buffer, then pop in exactly the stop-sample cycle of the next frame.
        for (int i = 0; i < DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b1, 10);
        fork
            send_frame(8'h99, 1'b1, 10);
            begin
                repeat (97) @(posedge clk);
                rd(A_RX, 32'h10, "rx_pushpop");
            end
        join
`ifdef WB_UART_RX_FIFO_EN
        rd(A_ST, 32'h41, "status_pushpop");
        rd(A_RX, 32'h11, "rx_pp_1");
        rd(A_RX, 32'h12, "rx_pp_2");
        rd(A_RX, 32'h13, "rx_pp_3");
`else
        rd(A_ST, 32'h11, "status_pushpop");
`endif
        rd(A_RX, 32'h99, "rx_pp_99");

        send_frame(8'h77, 1'b1, 10);
        check("irq_77", {31'd0, rx_irq}, 32'd1);
        fork
            send_frame(8'hFF, 1'b1, 10);
            begin
                repeat (55) @(posedge clk);
                #1 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
                @(negedge clk);
                check("midrst_ack", {31'd0, wb_ack}, 32'd0);
                check("midrst_data", wb_rdat, 32'd0);
                check("midrst_irq", {31'd0, rx_irq}, 32'd0);
            end
        join
        repeat (20) @(posedge clk);
        rd(A_ST, 32'h00, "status_midrst");
        rd(A_DIV, 32'd1, "div_midrst");
        rd(A_RX, 32'h00, "rx_midrst");
        wr(A_DIV, 32'd8, "wr_div_again");
        send_frame(8'h81, 1'b1, 10);
        rd(A_RX, 32'h81, "rx_81");
        rd(A_ST, 32'h00, "status_final");

        repeat (4) @(posedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
